// File: rtl/frame_deframer_pkg.sv
// -----------------------------------------------------------------------------
// frame_deframer_pkg
//   Items shared by the frame deframer and the header adder that builds its
//   input, so both ends agree on frame geometry and state encoding.
//   - state_e             : deframer FSM encoding (DATA=0, META=1, SEQ=2)
//   - DEFAULT_FRAME_BEATS : payload beats per frame
//   - DEFAULT_META_BEATS  : metadata beats per frame
//   - all_ones_keep()     : all-ones tkeep pattern for a given data width
// -----------------------------------------------------------------------------
package frame_deframer_pkg;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_META = 2'd1,
    ST_SEQ  = 2'd2
  } state_e;

  localparam int DEFAULT_FRAME_BEATS = 129;
  localparam int DEFAULT_META_BEATS  = 2;

  // Widest tkeep the helper can describe (data widths up to 1024 bits).
  localparam int MAX_KEEP_W = 128;

  // Low dw/8 bits set, the rest clear; callers slice to their own width.
  function automatic logic [MAX_KEEP_W-1:0] all_ones_keep(input int dw);
    logic [MAX_KEEP_W-1:0] keep;
    keep = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < dw / 8) begin
        keep[i] = 1'b1;
      end
    end
    return keep;
  endfunction

endpackage

// File: rtl/frame_deframer_seq_checker.sv
// -----------------------------------------------------------------------------
// seq_checker
//   Tracks the per-frame sequence number and flags discontinuities.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset
//     strobe      : counter beat accepted this cycle
//     value       : sequence number carried by that beat
//     seq_num     : most recently received sequence number
//     seq_err     : one-cycle pulse when value != previous + 1 (mod 2^SEQ_W)
//     err_count   : saturating count of discontinuities
// -----------------------------------------------------------------------------
module seq_checker
  import frame_deframer_pkg::*;
#(
  parameter int SEQ_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             strobe,
  input  logic [SEQ_W-1:0] value,
  output logic [SEQ_W-1:0] seq_num,
  output logic             seq_err,
  output logic [15:0]      err_count
);

  logic             seq_seen_reg;
  logic [SEQ_W-1:0] seq_num_reg;
  logic             seq_err_reg;
  logic [15:0]      err_count_reg;
  logic             mismatch;

  // The first frame after reset only establishes the reference value.
  // The sum is SEQ_W wide so the all-ones -> zero wrap counts as continuous.
  assign mismatch = seq_seen_reg && (value != (seq_num_reg + SEQ_W'(1)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_seen_reg  <= 1'b0;
      seq_num_reg   <= '0;
      seq_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      seq_err_reg <= strobe & mismatch;
      if (strobe) begin
        // Always take the received value so one glitch costs one error.
        seq_num_reg  <= value;
        seq_seen_reg <= 1'b1;
        if (mismatch && (err_count_reg != 16'hFFFF)) begin
          err_count_reg <= err_count_reg + 16'd1;
        end
      end
    end
  end

  assign seq_num   = seq_num_reg;
  assign seq_err   = seq_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: rtl/frame_deframer.sv
// -----------------------------------------------------------------------------
// frame_deframer
//   Consumes frames of FRAME_BEATS payload beats, META_BEATS metadata beats and
//   one sequence-counter beat. Payload is forwarded through a single register
//   stage as AXI-Stream with tlast on the final payload beat; metadata and the
//   counter are stripped and exposed as status.
//   Ports:
//     clk, resetn     : clock, asynchronous active-low reset
//     s_axis_*        : input stream (tdata/tvalid/tready)
//     m_axis_*        : payload stream (tdata/tvalid/tready/tlast/tkeep)
//     meta_tdata      : last metadata beat of the most recent frame
//     meta_valid      : sticky, set by the first complete frame
//     seq_num         : sequence number of the most recent frame
//     frame_done      : pulse after the counter beat is accepted
//     seq_err         : pulse with frame_done on sequence discontinuity
//     err_count       : saturating discontinuity count
//     frame_count     : wrapping completed-frame count
//     fsm_state       : current FSM state
// -----------------------------------------------------------------------------
module frame_deframer
  import frame_deframer_pkg::*;
#(
  parameter int DW          = 128,
  parameter int FRAME_BEATS = DEFAULT_FRAME_BEATS,
  parameter int META_BEATS  = DEFAULT_META_BEATS,
  parameter int SEQ_W       = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DW-1:0]     s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DW-1:0]     m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [DW/8-1:0]   m_axis_tkeep,
  output logic [DW-1:0]     meta_tdata,
  output logic              meta_valid,
  output logic [SEQ_W-1:0]  seq_num,
  output logic              frame_done,
  output logic              seq_err,
  output logic [15:0]       err_count,
  output logic [31:0]       frame_count,
  output logic [1:0]        fsm_state
);

  localparam int KEEP_W = DW / 8;
  localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int MD_W   = (META_BEATS > 1) ? $clog2(META_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);
  localparam logic [MD_W-1:0]   LAST_MD   = MD_W'(META_BEATS - 1);
  localparam logic [MAX_KEEP_W-1:0] KEEP_ALL = all_ones_keep(DW);

  state_e            state_reg, state_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [MD_W-1:0]   md_cnt_reg, md_cnt_next;

  logic [DW-1:0]     m_tdata_reg;
  logic              m_tvalid_reg;
  logic              m_tlast_reg;
  logic [DW-1:0]     meta_tdata_reg;
  logic              meta_valid_reg;
  logic              frame_done_reg;
  logic [31:0]       frame_count_reg;

  logic              s_ready;
  logic              accept;
  logic              load_out;
  logic              load_last;
  logic              meta_load;
  logic              seq_strobe;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    md_cnt_next   = md_cnt_reg;
    s_ready       = 1'b0;
    accept        = 1'b0;
    load_out      = 1'b0;
    load_last     = 1'b0;
    meta_load     = 1'b0;
    seq_strobe    = 1'b0;

    case (state_reg)
      ST_DATA: begin
        // Payload may only enter when the output stage is empty or draining.
        s_ready = resetn & (~m_tvalid_reg | m_axis_tready);
        accept  = s_axis_tvalid & s_ready;
        if (accept) begin
          load_out = 1'b1;
          if (beat_cnt_reg == LAST_BEAT) begin
            load_last     = 1'b1;
            beat_cnt_next = '0;
            state_next    = ST_META;
          end else begin
            beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
          end
        end
      end
      ST_META: begin
        // Metadata and counter beats never touch the output stage.
        s_ready = resetn;
        accept  = s_axis_tvalid & s_ready;
        if (accept) begin
          meta_load = 1'b1;
          if (md_cnt_reg == LAST_MD) begin
            md_cnt_next = '0;
            state_next  = ST_SEQ;
          end else begin
            md_cnt_next = md_cnt_reg + MD_W'(1);
          end
        end
      end
      ST_SEQ: begin
        s_ready = resetn;
        accept  = s_axis_tvalid & s_ready;
        if (accept) begin
          seq_strobe = 1'b1;
          state_next = ST_DATA;
        end
      end
      default: begin
        state_next = ST_DATA;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_DATA;
      beat_cnt_reg <= '0;
      md_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      md_cnt_reg   <= md_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage: load and drain may coincide for full throughput.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_tdata_reg  <= '0;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
    end else if (load_out) begin
      m_tdata_reg  <= s_axis_tdata;
      m_tlast_reg  <= load_last;
      m_tvalid_reg <= 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Metadata and frame statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_tdata_reg  <= '0;
      meta_valid_reg  <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      frame_done_reg <= seq_strobe;
      if (meta_load) begin
        meta_tdata_reg <= s_axis_tdata;
      end
      if (seq_strobe) begin
        meta_valid_reg  <= 1'b1;
        frame_count_reg <= frame_count_reg + 32'd1;
      end
    end
  end

  seq_checker #(
    .SEQ_W (SEQ_W)
  ) u_seq (
    .clk       (clk),
    .resetn    (resetn),
    .strobe    (seq_strobe),
    .value     (s_axis_tdata[SEQ_W-1:0]),
    .seq_num   (seq_num),
    .seq_err   (seq_err),
    .err_count (err_count)
  );

  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_keep
    assign m_axis_tkeep[gi] = KEEP_ALL[gi];
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tlast  = m_tlast_reg;
  assign meta_tdata    = meta_tdata_reg;
  assign meta_valid    = meta_valid_reg;
  assign frame_done    = frame_done_reg;
  assign frame_count   = frame_count_reg;
  assign fsm_state     = state_reg;

endmodule

// File: tb/tb_frame_deframer.sv
module tb_frame_deframer;

  localparam int DW = 32;
  localparam int FB = 4;
  localparam int MB = 2;
  localparam int SW = 8;
  localparam int FL = FB + MB + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [3:0]    m_axis_tkeep;
  logic [DW-1:0] meta_tdata;
  logic          meta_valid;
  logic [SW-1:0] seq_num;
  logic          frame_done;
  logic          seq_err;
  logic [15:0]   err_count;
  logic [31:0]   frame_count;
  logic [1:0]    fsm_state;

  frame_deframer #(
    .DW(DW), .FRAME_BEATS(FB), .META_BEATS(MB), .SEQ_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep),
    .meta_tdata(meta_tdata), .meta_valid(meta_valid), .seq_num(seq_num),
    .frame_done(frame_done), .seq_err(seq_err), .err_count(err_count),
    .frame_count(frame_count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frame position counted over accepted beats; expected
  // payload transfers kept in a queue; frame status derived per frame.
  // ---------------------------------------------------------------------------
  logic [32:0] exp_q[$];
  int          pos;
  bit          seen;
  logic [7:0]  m_seq;
  logic [15:0] m_err;
  logic [31:0] m_fc;
  logic [31:0] m_meta;
  bit          m_mv;
  bit          pend_frame, pend_err, pend_load, pend_last, pend_stall;
  logic [31:0] pend_data, stall_data;
  bit          rand_ready = 1'b0;

  initial begin : monitor
    logic [32:0] e;
    logic [7:0]  d;
    bit          err;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        pos = 0; seen = 0; m_seq = '0; m_err = '0; m_fc = '0; m_meta = '0; m_mv = 0;
        pend_frame = 0; pend_err = 0; pend_load = 0; pend_stall = 0;
      end else begin
        chk("frame_done", frame_done, pend_frame);
        chk("seq_err", seq_err, pend_frame & pend_err);
        chk("seq_num", seq_num, m_seq);
        chk("err_count", err_count, m_err);
        chk("frame_count", frame_count, m_fc);
        chk("meta_tdata", meta_tdata, m_meta);
        chk("meta_valid", meta_valid, m_mv);
        chk("tkeep", m_axis_tkeep, 4'hF);
        chk("fsm_state", fsm_state, (pos < FB) ? 0 : (pos < FB + MB) ? 1 : 2);
        chk("s_tready", s_axis_tready, (pos < FB) ? (!m_axis_tvalid || m_axis_tready) : 1'b1);
        if (pend_load) begin
          chk("latency_valid", m_axis_tvalid, 1'b1);
          chk("latency_data", m_axis_tdata, pend_data);
          chk("latency_last", m_axis_tlast, pend_last);
        end
        if (pend_stall) begin
          chk("stall_valid", m_axis_tvalid, 1'b1);
          chk("stall_data", m_axis_tdata, stall_data);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          chk("out_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", m_axis_tdata, e[31:0]);
            chk("out_last", m_axis_tlast, e[32]);
          end
        end
        pend_load  = 0;
        pend_frame = 0;
        pend_stall = m_axis_tvalid && !m_axis_tready;
        stall_data = m_axis_tdata;
        if (s_axis_tvalid && s_axis_tready) begin
          if (pos < FB) begin
            exp_q.push_back({pos == FB - 1, s_axis_tdata});
            pend_load = 1; pend_data = s_axis_tdata; pend_last = (pos == FB - 1);
          end else if (pos < FB + MB) begin
            m_meta = s_axis_tdata;
          end else begin
            d   = s_axis_tdata[7:0];
            err = seen && (d != 8'(m_seq + 8'd1));
            if (err && m_err != 16'hFFFF) m_err = m_err + 16'd1;
            m_seq = d; seen = 1; m_fc = m_fc + 32'd1; m_mv = 1;
            pend_frame = 1; pend_err = err;
          end
          pos = (pos + 1) % FL;
        end
      end
    end
  end

  // Random downstream back-pressure during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 50);
    chk("s_accept", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [31:0] base, input bit rnd, input logic [7:0] sq, input int gap);
    for (int i = 0; i < FB; i++) begin
      send(rnd ? $urandom : base + 32'(i));
      if (gap > 0) idle($urandom_range(0, gap));
    end
    for (int i = 0; i < MB; i++) begin
      send(rnd ? $urandom : 32'hA0 + 32'(i));
      if (gap > 0) idle($urandom_range(0, gap));
    end
    send(rnd ? {$urandom_range(0, 32'hFFFFFF), sq} : {24'h0, sq});
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed + randomized sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    logic [7:0] cur;
    logic [7:0] sq;
    resetn        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_meta_valid", meta_valid, 1'b0);
    chk("rst_err_count", err_count, 16'h0);
    chk("rst_frame_count", frame_count, 32'h0);
    chk("rst_state", fsm_state, 2'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;

    // Frame 1: payload 0x10..0x13, meta A0/A1, seq 05
    send_frame(32'h10, 1'b0, 8'h05, 0);
    chk("f1_frame_done", frame_done, 1'b1);
    chk("f1_seq_num", seq_num, 8'h05);
    chk("f1_seq_err", seq_err, 1'b0);
    chk("f1_meta", meta_tdata, 32'hA1);
    chk("f1_meta_valid", meta_valid, 1'b1);
    chk("f1_frame_count", frame_count, 32'd1);

    // Continuity then a jump
    send_frame(32'h20, 1'b0, 8'h06, 0);
    chk("f2_seq_err", seq_err, 1'b0);
    send_frame(32'h30, 1'b0, 8'h09, 0);
    chk("f3_seq_err", seq_err, 1'b1);
    chk("f3_err_count", err_count, 16'd1);
    chk("f3_seq_num", seq_num, 8'h09);

    // Wrap FF -> 00 is continuous (FF after 09 is a jump)
    send_frame(32'h40, 1'b0, 8'hFF, 0);
    send_frame(32'h50, 1'b0, 8'h00, 0);
    chk("wrap_seq_err", seq_err, 1'b0);
    chk("wrap_err_count", err_count, 16'd2);

    // Downstream stall during payload
    m_axis_tready = 1'b0;
    fork
      send_frame(32'h60, 1'b0, 8'h01, 0);
      begin
        repeat (3) @(negedge clk);
        chk("stall_s_tready", s_axis_tready, 1'b0);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    idle(2);

    // Saturation of the error counter
    force dut.u_seq.err_count_reg = 16'hFFFE;
    m_err = 16'hFFFE;
    @(negedge clk);
    release dut.u_seq.err_count_reg;
    @(posedge clk); #1;
    send_frame(32'h70, 1'b0, 8'h50, 0);
    send_frame(32'h80, 1'b0, 8'h70, 0);
    send_frame(32'h90, 1'b0, 8'h90, 0);
    chk("sat_err_count", err_count, 16'hFFFF);
    cur = 8'h90;

    // Randomized frames with gaps and back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      sq  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(cur + 8'd1);
      cur = sq;
      send_frame(32'h0, 1'b1, sq, 2);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    m_axis_tready = 1'b1;
    idle(3);
    chk("drain_empty", exp_q.size(), 0);

    // Asynchronous reset mid-frame, after payload beat 2
    send(32'hC0);
    send(32'hC1);
    send(32'hC2);
    resetn = 1'b0;
    #1;
    chk("arst_tvalid", m_axis_tvalid, 1'b0);
    chk("arst_tdata", m_axis_tdata, 32'h0);
    chk("arst_tlast", m_axis_tlast, 1'b0);
    chk("arst_tready", s_axis_tready, 1'b0);
    chk("arst_meta", meta_tdata, 32'h0);
    chk("arst_seq_num", seq_num, 8'h0);
    chk("arst_err_count", err_count, 16'h0);
    chk("arst_frame_count", frame_count, 32'h0);
    chk("arst_state", fsm_state, 2'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    send_frame(32'hD0, 1'b0, 8'h33, 0);
    chk("post_rst_frame_count", frame_count, 32'd1);
    chk("post_rst_seq_err", seq_err, 1'b0);
    idle(3);
    chk("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_deframer.md
Name: frame_deframer

Overview:
- Downstream consumer of the header-adder output path.
- Input is a repeating frame: FRAME_BEATS payload beats, then META_BEATS metadata beats, then one sequence-counter beat.
- Strips metadata and counter, and forwards payload as an AXI-Stream with tlast on the final payload beat.
- Latches metadata, checks sequence-number continuity and keeps error/frame statistics for the host.

Parameters:
- DW, 128, data width of input, output and metadata.
- FRAME_BEATS, 129, payload beats per frame (≥1).
- META_BEATS, 2, metadata beats per frame (≥1).
- SEQ_W, 32, sequence-number width taken from tdata[SEQ_W-1:0] of the counter beat (≤DW).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  DW  input stream data
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DW  payload data
- m_axis_tvalid  out  1  payload valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last payload beat of frame
- m_axis_tkeep  out  DW/8  byte enables, always all-ones
- meta_tdata  out  DW  last metadata beat of most recent frame
- meta_valid  out  1  high once the first complete frame is received; sticky until reset
- seq_num  out  SEQ_W  sequence number of most recent frame
- frame_done  out  1  one-cycle pulse on acceptance of the counter beat
- seq_err  out  1  one-cycle pulse, coincident with frame_done, on discontinuity
- err_count  out  16  saturating discontinuity count
- frame_count  out  32  wrapping count of completed frames
- fsm_state  out  2  current state, for debug

Behaviour:
- Reset: clk and resetn are the only clock and reset. Reset is asynchronous, active-low, and clears every register. While resetn=0:
  - state = DATA, beat counters = 0
  - all output regs = 0, m_axis_tvalid = 0, s_axis_tready = 0
  - meta_valid = 0, err_count = 0, frame_count = 0
  - Assertion mid-frame discards the partial frame; the first beat after release is payload beat 0.
- Handshake: a beat is accepted when s_axis_tvalid & s_axis_tready. The output is a single register stage.
- s_axis_tready rules:
  - DATA: s_axis_tready = resetn & (~m_axis_tvalid | m_axis_tready).
  - META and SEQ: s_axis_tready = resetn (never back-pressured).
- Output register:
  - Loads on an accepted DATA beat, setting m_axis_tvalid=1.
  - Clears m_axis_tvalid when m_axis_tready=1 and no new load occurs.
  - Load and drain in the same cycle is allowed (full throughput).
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid & ~m_axis_tready.
- States (2-bit: DATA=0, META=1, SEQ=2; 3 is unreachable and returns to DATA):
  - DATA: each accepted beat increments beat_cnt. The beat with beat_cnt==FRAME_BEATS-1 is loaded with tlast=1; beat_cnt is cleared and the state goes to META.
  - META: each accepted beat is written to meta_tdata (last beat wins) and increments md_cnt. On md_cnt==META_BEATS-1, md_cnt is cleared and the state goes to SEQ.
  - SEQ: on the accepted beat:
    - seq_num <= tdata[SEQ_W-1:0]
    - frame_done pulses
    - frame_count increments, wrapping
    - meta_valid <= 1
    - state goes to DATA
- Sequence check:
  - No check on the first frame after reset (seq_seen=0); seq_seen is set at that frame.
  - Afterwards, seq_err=1 iff new != seq_num+1 mod 2^SEQ_W. 2^SEQ_W-1 followed by 0 is continuous.
  - On seq_err, err_count increments, saturating at 16'hFFFF.
  - seq_num always updates to the received value, so the check resynchronises.
- s_axis_tvalid low in any state leaves the state and counters unchanged.

Decomposition:
- Shared package:
  - state encoding constants DATA/META/SEQ
  - all-ones tkeep constant function of DW
  - default FRAME_BEATS/META_BEATS, shared with the header adder so both ends agree on frame geometry
- One sub-module: seq_checker (inputs: strobe, value; outputs: seq_num, seq_err, err_count). It holds seq_seen, the comparison and the saturating counter.

Test Plan (bench params FRAME_BEATS=4, META_BEATS=2, SEQ_W=8, DW=32):
- Reset release, then stream 0x10,0x11,0x12,0x13, meta 0xA0,0xA1, seq 0x05 with m_axis_tready=1:
  - m_axis outputs 0x10..0x13 one cycle delayed; tlast only on 0x13.
  - meta_tdata=0xA1, seq_num=0x05, frame_done pulse, seq_err=0, frame_count=1, meta_valid=1.
- Second frame seq 0x06, third seq 0x09:
  - No error on 0x06.
  - seq_err pulse with 0x09; err_count=1, seq_num=0x09.
- Frame with seq 0xFF then frame with seq 0x00:
  - No seq_err (wrap continuity).
- Hold m_axis_tready=0 for 3 cycles during DATA with s_axis_tvalid=1:
  - s_axis_tready=0 after the first load; m_axis_tdata stable; no beat lost or duplicated after release.
- Force err_count to 0xFFFE, then send 3 discontinuous frames:
  - err_count stays at 0xFFFF.
- Assert resetn=0 asynchronously after payload beat 2:
  - All outputs 0 without a clock edge.
  - After release, the next 4 beats are treated as payload with tlast on the 4th.
